// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scanner: FSM states,
// the hex-to-segment table and the leading-zero helper.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Segment codes, bits a..g,dp = [7:0]; entry n is the glyph for nibble n.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h9E, 8'h7A, 8'h1A, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    localparam int LZ_MAX_D = 16;

    // nz holds one "nibble is nonzero" flag per digit of a register. Digit d
    // is a leading zero when no digit at or above it is nonzero; digit 0 is
    // never suppressed so a zero register still shows a single "0".
    function automatic logic lz_mask_bit(input logic [LZ_MAX_D-1:0] nz, input int d);
        logic higher_nz;
        higher_nz = 1'b0;
        for (int k = 0; k < LZ_MAX_D; k++) begin
            if (k >= d) begin
                higher_nz = higher_nz | nz[k];
            end else begin
                higher_nz = higher_nz;
            end
        end
        return (d != 0) && !higher_nz;
    endfunction

endpackage

// File: rtl/seg_hex_enc.sv
// One digit: nibble plus blank request to an 8-bit segment pattern,
// inverted as a whole for boards with active-low segment drivers.
module seg_hex_enc
    import seg_pkg::*;
#(
    parameter int SEG_POL = 1
) (
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [7:0] code_o
);

    logic [7:0] raw_s;

    // Table lookup, then polarity.
    always_comb begin
        raw_s = blank_i ? SEG_BLANK : HEX_SEG[nib_i];
        if (SEG_POL != 0) begin
            code_o = raw_s;
        end else begin
            code_o = ~raw_s;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner: per-frame snapshot of the register
// file, slot timer with anti-ghost blanking, and registered strobe/segment outputs.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_REGS  = 8,
    parameter int REG_W     = 16,
    parameter int NUM_SEL   = 4,
    parameter int SCAN_DIV  = 1024,
    parameter int BLANK_CYC = 16,
    parameter int SEG_POL   = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_REGS*REG_W-1:0]                     reg_in,
    input  logic                                          en,
    input  logic                                          lz_blank,
    output logic [NUM_SEL-1:0]                            sel_n,
    output logic [(NUM_REGS/NUM_SEL)*(REG_W/4)*8-1:0]     seg_out,
    output logic                                          frame_tick
);

    localparam int R     = NUM_REGS / NUM_SEL;
    localparam int D     = REG_W / 4;
    localparam int NDIG  = R * D;
    localparam int SEL_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [7:0]        BLANK_CODE = (SEG_POL != 0) ? SEG_BLANK : ~SEG_BLANK;
    localparam logic [NDIG*8-1:0] BLANK_FILL = {NDIG{BLANK_CODE}};

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SEL_W-1:0]     slot_q, slot_d;
    logic [REG_W-1:0]     shadow_q [NUM_REGS];
    logic                 lz_q;
    logic                 snap_s;
    logic                 frame_tick_q, frame_tick_d;
    logic [NUM_SEL-1:0]   sel_n_q, sel_n_d;
    logic [NDIG*8-1:0]    seg_out_q, seg_out_d;
    logic [REG_W-1:0]     slot_reg_s [R];
    logic [7:0]           dec_s [NDIG];

    // Pick the R shadow registers belonging to the current slot.
    always_comb begin
        for (int r = 0; r < R; r++) begin
            slot_reg_s[r] = '0;
            for (int k = 0; k < NUM_SEL; k++) begin
                slot_reg_s[r] = (slot_q == SEL_W'(k)) ? shadow_q[k*R + r] : slot_reg_s[r];
            end
        end
    end

    for (genvar gr = 0; gr < R; gr++) begin : g_reg
        logic [LZ_MAX_D-1:0] nz_s;

        // Nonzero flag per digit; unused upper flags stay zero.
        always_comb begin
            nz_s = '0;
            for (int d = 0; d < D; d++) begin
                nz_s[d] = |slot_reg_s[gr][4*d +: 4];
            end
        end

        for (genvar gd = 0; gd < D; gd++) begin : g_dig
            logic blank_s;
            assign blank_s = lz_q && lz_mask_bit(nz_s, gd);

            seg_hex_enc #(.SEG_POL(SEG_POL)) u_enc (
                .nib_i   (slot_reg_s[gr][4*gd +: 4]),
                .blank_i (blank_s),
                .code_o  (dec_s[gr*D + gd])
            );
        end
    end

    // Next state, counters and the registered-output next values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        slot_d       = slot_q;
        snap_s       = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            slot_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    slot_d  = '0;
                    snap_s  = 1'b1;
                end
                BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
                        state_d = ON;
                    end else begin
                        state_d = BLANK;
                    end
                end
                ON: begin
                    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (slot_q == SEL_W'(NUM_SEL - 1)) begin
                            slot_d = '0;
                            snap_s = 1'b1;
                        end else begin
                            slot_d = slot_q + SEL_W'(1);
                        end
                    end else begin
                        state_d = ON;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    slot_d  = '0;
                end
            endcase
        end

        frame_tick_d = snap_s;

        for (int k = 0; k < NUM_SEL; k++) begin
            sel_n_d[k] = !((state_d == ON) && (slot_d == SEL_W'(k)));
        end

        // Segments reload one cycle after slot entry, with strobes still dark.
        if (state_d == IDLE) begin
            seg_out_d = BLANK_FILL;
        end else if ((state_q == BLANK) && (cnt_q == '0)) begin
            for (int i = 0; i < NDIG; i++) begin
                seg_out_d[8*i +: 8] = dec_s[i];
            end
        end else begin
            seg_out_d = seg_out_q;
        end
    end

    // FSM, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            slot_q       <= '0;
            frame_tick_q <= 1'b0;
            sel_n_q      <= '1;
            seg_out_q    <= BLANK_FILL;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            frame_tick_q <= frame_tick_d;
            sel_n_q      <= sel_n_d;
            seg_out_q    <= seg_out_d;
        end
    end

    // Frame snapshot of the register file and blanking mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lz_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (snap_s) begin
            lz_q <= lz_blank;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= reg_in[REG_W*i +: REG_W];
            end
        end else begin
            lz_q <= lz_q;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= shadow_q[i];
            end
        end
    end

    assign sel_n      = sel_n_q;
    assign seg_out    = seg_out_q;
    assign frame_tick = frame_tick_q;

endmodule
